alu_32bit: RTL and testbench
============================

ALU_32BIT -- requirements
Module: alu_32bit

Interface
REQ-001 Parameters: none; datapath width fixed at 32 bits.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  instruction/operands valid this cycle.
REQ-005 instruction  input  32  MIPS-format instruction word.
REQ-006 pc  input  32  word-indexed PC of the instruction.
REQ-007 rs_data, rt_data  input  32 each  register-file contents for rs/rt.
REQ-008 out_valid  output  1  registered result valid.
REQ-009 opcode[5:0], rs[4:0], rt[4:0], rd[4:0], shamt[4:0], funct[5:0], immediate[15:0], address[25:0]  output  parsed fields.
REQ-010 read_reg, write_reg, read_mem, write_mem, reg_dst, branch  output  1 each  control signals.
REQ-011 dest_reg  output  5  write-back register index.
REQ-012 alu_result  output  32  ALU output; zero  output  1  alu_result==0.
REQ-013 illegal  output  1  unsupported opcode/funct; overflow  output  1  signed-overflow flag.

Function
REQ-014 Latency: exactly 1 cycle; outputs registered at the rising edge where in_valid=1; out_valid=in_valid delayed 1 cycle.
REQ-015 in_valid=0: out_valid=0 next edge; all other outputs hold.
REQ-016 Fields: opcode=[31:26], rs=[25:21], rt=[20:16], rd=[15:11], shamt=[10:6], funct=[5:0], immediate=[15:0], address=[25:0], extracted for every opcode.
REQ-017 sext=sign-extended immediate; zext=zero-extended immediate; all arithmetic mod 2^32.
REQ-018 R-type (opcode 0x00), result on funct: 0x20/0x21 rs+rt; 0x22/0x23 rs-rt; 0x24 AND; 0x25 OR; 0x26 XOR; 0x27 NOR; 0x2A signed rs<rt ?1:0; 0x2B unsigned; 0x00 rt<<shamt; 0x02 rt>>shamt logical; 0x03 arithmetic; 0x08 jr result=rs_data.
REQ-019 R-type control: read_reg=1, reg_dst=1, write_reg=1 (jr: write_reg=0); dest_reg=rd.
REQ-020 I-type: 0x08/0x09 rs+sext; 0x0A signed slt vs sext; 0x0B unsigned slt vs sext; 0x0C AND zext; 0x0D OR zext; 0x0E XOR zext; 0x0F imm<<16; read_reg=1, write_reg=1, reg_dst=0, dest_reg=rt.
REQ-021 lw 0x23: result rs+sext, read_mem=1, write_reg=1, dest_reg=rt; sw 0x2B: result rs+sext, write_mem=1, write_reg=0.
REQ-022 beq 0x04: result rs-rt, branch=1; bne 0x05: result (rs==rt)?1:0, branch=1; taken iff branch=1 and zero=1; write_reg=0.
REQ-023 j 0x02: all controls 0, result 0; jal 0x03: result pc+1, write_reg=1, dest_reg=31.
REQ-024 Unsupported opcode/funct: illegal=1, all controls 0, result 0, fields still decoded.
REQ-025 zero computed from the registered alu_result in the same cycle (combinational from it).

Reset
REQ-026 reset_n=0 asynchronously clears every output and register to 0 (zero=1); release takes effect at the next rising edge only.
REQ-027 Reset asserted mid-operation discards the in-flight instruction; out_valid=0 after release until a new in_valid.

Configuration
REQ-028 Macro ALU32_OVERFLOW_TRAP_EN defined: add(0x20), sub(0x22), addi(0x08) signed overflow sets overflow=1 and forces write_reg=0; result still the wrapped value.
REQ-029 Macro undefined: overflow tied 0, no write suppression; addu/subu/addiu never flag in either build.

Verification
REQ-030 reset_n=0 mid-stream -> all outputs 0, zero=1, out_valid=0 immediately.
REQ-031 add rs=5, rt=7 (0x00A53820 style, funct 0x20) -> next cycle alu_result=12, write_reg=1, reg_dst=1, dest_reg=rd.
REQ-032 beq rs_data=rt_data=0x1234 -> alu_result=0, zero=1, branch=1; bne same operands -> alu_result=1, zero=0.
REQ-033 sra shamt=4, rt=0x80000000 -> 0xF8000000; lui imm=0xABCD -> 0xABCD0000; ori imm=0x8001 rs=0 -> 0x00008001.
REQ-034 add 0x7FFFFFFF+1 -> result 0x80000000; overflow=1, write_reg=0 with ALU32_OVERFLOW_TRAP_EN, overflow=0, write_reg=1 without.
REQ-035 opcode 0x3F -> illegal=1, all controls 0, result 0; in_valid=0 next cycle -> out_valid=0, outputs hold.

Source files
------------

// File: rtl/alu_32bit.sv
// Single-cycle MIPS-style decode + 32-bit ALU with registered outputs.
// Optional build macro ALU32_OVERFLOW_TRAP_EN enables signed-overflow trapping on add/sub/addi.
`timescale 1ns/1ps
module alu_32bit (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  input  logic [31:0] instruction,
  input  logic [31:0] pc,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        out_valid,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  output logic [15:0] immediate,
  output logic [25:0] address,
  output logic        read_reg,
  output logic        write_reg,
  output logic        read_mem,
  output logic        write_mem,
  output logic        reg_dst,
  output logic        branch,
  output logic [4:0]  dest_reg,
  output logic [31:0] alu_result,
  output logic        zero,
  output logic        illegal,
  output logic        overflow
);

  localparam int unsigned W = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03,
                         OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDI = 6'h08,
                         OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B,
                         OP_ANDI  = 6'h0C, OP_ORI  = 6'h0D, OP_XORI = 6'h0E,
                         OP_LUI   = 6'h0F, OP_LW   = 6'h23, OP_SW   = 6'h2B;

  localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_SRA = 6'h03, F_JR = 6'h08,
                         F_ADD = 6'h20, F_ADDU = 6'h21, F_SUB = 6'h22, F_SUBU = 6'h23,
                         F_AND = 6'h24, F_OR = 6'h25, F_XOR = 6'h26, F_NOR = 6'h27,
                         F_SLT = 6'h2A, F_SLTU = 6'h2B;

  logic [5:0]   op_c, funct_c;
  logic [4:0]   shamt_c;
  logic [W-1:0] sext_c, zext_c;

  assign op_c    = instruction[31:26];
  assign funct_c = instruction[5:0];
  assign shamt_c = instruction[10:6];
  assign sext_c  = {{16{instruction[15]}}, instruction[15:0]};
  assign zext_c  = {16'h0000, instruction[15:0]};

  logic [W-1:0] result_nxt;
  logic [4:0]   dest_nxt;
  logic         read_reg_nxt, write_reg_raw, write_reg_nxt, read_mem_nxt, write_mem_nxt;
  logic         reg_dst_nxt, branch_nxt, illegal_nxt, ovf_c;

  // Decode and execute; unsupported encodings leave every control at 0.
  always_comb begin
    result_nxt    = '0;
    dest_nxt      = '0;
    read_reg_nxt  = 1'b0;
    write_reg_raw = 1'b0;
    read_mem_nxt  = 1'b0;
    write_mem_nxt = 1'b0;
    reg_dst_nxt   = 1'b0;
    branch_nxt    = 1'b0;
    illegal_nxt   = 1'b0;
    case (op_c)
      OP_RTYPE: begin
        read_reg_nxt  = 1'b1;
        reg_dst_nxt   = 1'b1;
        write_reg_raw = 1'b1;
        dest_nxt      = instruction[15:11];
        case (funct_c)
          F_ADD, F_ADDU: result_nxt = rs_data + rt_data;
          F_SUB, F_SUBU: result_nxt = rs_data - rt_data;
          F_AND:  result_nxt = rs_data & rt_data;
          F_OR:   result_nxt = rs_data | rt_data;
          F_XOR:  result_nxt = rs_data ^ rt_data;
          F_NOR:  result_nxt = ~(rs_data | rt_data);
          F_SLT:  result_nxt = W'($signed(rs_data) < $signed(rt_data));
          F_SLTU: result_nxt = W'(rs_data < rt_data);
          F_SLL:  result_nxt = rt_data << shamt_c;
          F_SRL:  result_nxt = rt_data >> shamt_c;
          F_SRA:  result_nxt = W'($signed(rt_data) >>> shamt_c);
          F_JR: begin
            result_nxt    = rs_data;
            write_reg_raw = 1'b0;
          end
          default: begin
            illegal_nxt   = 1'b1;
            read_reg_nxt  = 1'b0;
            reg_dst_nxt   = 1'b0;
            write_reg_raw = 1'b0;
            dest_nxt      = '0;
          end
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        read_reg_nxt  = 1'b1;
        write_reg_raw = 1'b1;
        dest_nxt      = instruction[20:16];
        case (op_c)
          OP_SLTI:  result_nxt = W'($signed(rs_data) < $signed(sext_c));
          OP_SLTIU: result_nxt = W'(rs_data < sext_c);
          OP_ANDI:  result_nxt = rs_data & zext_c;
          OP_ORI:   result_nxt = rs_data | zext_c;
          OP_XORI:  result_nxt = rs_data ^ zext_c;
          OP_LUI:   result_nxt = {instruction[15:0], 16'h0000};
          default:  result_nxt = rs_data + sext_c;
        endcase
      end
      OP_LW: begin
        result_nxt    = rs_data + sext_c;
        read_reg_nxt  = 1'b1;
        read_mem_nxt  = 1'b1;
        write_reg_raw = 1'b1;
        dest_nxt      = instruction[20:16];
      end
      OP_SW: begin
        result_nxt    = rs_data + sext_c;
        read_reg_nxt  = 1'b1;
        write_mem_nxt = 1'b1;
      end
      OP_BEQ: begin
        result_nxt   = rs_data - rt_data;
        read_reg_nxt = 1'b1;
        branch_nxt   = 1'b1;
      end
      OP_BNE: begin
        // Inverted sense so that "zero" still means branch taken.
        result_nxt   = W'(rs_data == rt_data);
        read_reg_nxt = 1'b1;
        branch_nxt   = 1'b1;
      end
      OP_J: result_nxt = '0;
      OP_JAL: begin
        result_nxt    = pc + W'(1);
        write_reg_raw = 1'b1;
        dest_nxt      = 5'd31;
      end
      default: illegal_nxt = 1'b1;
    endcase
  end

`ifdef ALU32_OVERFLOW_TRAP_EN
  logic [W-1:0] ovf_b;
  logic         ovf_chk, ovf_sub;

  // Signed overflow on the trapping adds/subs; the wrapped result is still written out.
  always_comb begin
    ovf_chk = 1'b0;
    ovf_sub = 1'b0;
    ovf_b   = rt_data;
    if (op_c == OP_RTYPE && funct_c == F_ADD) begin
      ovf_chk = 1'b1;
    end else if (op_c == OP_RTYPE && funct_c == F_SUB) begin
      ovf_chk = 1'b1;
      ovf_sub = 1'b1;
    end else if (op_c == OP_ADDI) begin
      ovf_chk = 1'b1;
      ovf_b   = sext_c;
    end
    ovf_c = ovf_chk && (result_nxt[W-1] != rs_data[W-1]) &&
            (ovf_sub ? (rs_data[W-1] != ovf_b[W-1]) : (rs_data[W-1] == ovf_b[W-1]));
  end

  assign write_reg_nxt = write_reg_raw & ~ovf_c;
`else
  assign ovf_c         = 1'b0;
  assign write_reg_nxt = write_reg_raw;
`endif

  // Output register: capture on in_valid, otherwise hold everything except out_valid.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid  <= 1'b0;
      opcode     <= '0;
      rs         <= '0;
      rt         <= '0;
      rd         <= '0;
      shamt      <= '0;
      funct      <= '0;
      immediate  <= '0;
      address    <= '0;
      read_reg   <= 1'b0;
      write_reg  <= 1'b0;
      read_mem   <= 1'b0;
      write_mem  <= 1'b0;
      reg_dst    <= 1'b0;
      branch     <= 1'b0;
      dest_reg   <= '0;
      alu_result <= '0;
      illegal    <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        opcode     <= op_c;
        rs         <= instruction[25:21];
        rt         <= instruction[20:16];
        rd         <= instruction[15:11];
        shamt      <= shamt_c;
        funct      <= funct_c;
        immediate  <= instruction[15:0];
        address    <= instruction[25:0];
        read_reg   <= read_reg_nxt;
        write_reg  <= write_reg_nxt;
        read_mem   <= read_mem_nxt;
        write_mem  <= write_mem_nxt;
        reg_dst    <= reg_dst_nxt;
        branch     <= branch_nxt;
        dest_reg   <= dest_nxt;
        alu_result <= result_nxt;
        illegal    <= illegal_nxt;
        overflow   <= ovf_c;
      end
    end
  end

  assign zero = (alu_result == '0);

endmodule

// File: tb/tb_alu_32bit.sv
// Directed-vector bench for alu_32bit; expectations follow ALU32_OVERFLOW_TRAP_EN when defined.
`timescale 1ns/1ps
module tb_alu_32bit;

  logic        clock = 1'b0;
  logic        reset_n, in_valid;
  logic [31:0] instruction, pc, rs_data, rt_data;
  logic        out_valid;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt, dest_reg;
  logic [15:0] immediate;
  logic [25:0] address;
  logic        read_reg, write_reg, read_mem, write_mem, reg_dst, branch;
  logic [31:0] alu_result;
  logic        zero, illegal, overflow;

  int unsigned total = 0;
  int unsigned passed = 0;

  always #5 clock = ~clock;

  alu_32bit dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .instruction(instruction),
    .pc(pc), .rs_data(rs_data), .rt_data(rt_data), .out_valid(out_valid),
    .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
    .immediate(immediate), .address(address), .read_reg(read_reg), .write_reg(write_reg),
    .read_mem(read_mem), .write_mem(write_mem), .reg_dst(reg_dst), .branch(branch),
    .dest_reg(dest_reg), .alu_result(alu_result), .zero(zero), .illegal(illegal),
    .overflow(overflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] s, input logic [4:0] t,
                                        input logic [4:0] d, input logic [4:0] sh,
                                        input logic [5:0] f);
    return {6'h00, s, t, d, sh, f};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] s,
                                        input logic [4:0] t, input logic [15:0] imm);
    return {op, s, t, imm};
  endfunction

  // One valid instruction, sampled 1 ns after the capturing edge.
  task automatic run(input logic [31:0] ins, input logic [31:0] p,
                     input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    instruction = ins;
    pc          = p;
    rs_data     = a;
    rt_data     = b;
    in_valid    = 1'b1;
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0;
    instruction = '0; pc = '0; rs_data = '0; rt_data = '0;
    #12;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_result", alu_result, 0);
    check("rst_zero", 32'(zero), 1);
    check("rst_write_reg", 32'(write_reg), 0);
    @(negedge clock);
    reset_n = 1'b1;

    run(32'h00A53820, 0, 5, 7);
    check("add_valid", 32'(out_valid), 1);
    check("add_result", alu_result, 12);
    check("add_write_reg", 32'(write_reg), 1);
    check("add_reg_dst", 32'(reg_dst), 1);
    check("add_dest", 32'(dest_reg), 7);
    check("add_rs_field", 32'(rs), 5);
    check("add_funct_field", 32'(funct), 32'h20);
    check("add_zero", 32'(zero), 0);

    run(itype(6'h04, 5'd1, 5'd2, 16'h0010), 0, 32'h1234, 32'h1234);
    check("beq_result", alu_result, 0);
    check("beq_zero", 32'(zero), 1);
    check("beq_branch", 32'(branch), 1);
    check("beq_write_reg", 32'(write_reg), 0);
    check("beq_imm_field", 32'(immediate), 32'h10);

    run(itype(6'h05, 5'd1, 5'd2, 16'h0010), 0, 32'h1234, 32'h1234);
    check("bne_result", alu_result, 1);
    check("bne_zero", 32'(zero), 0);
    check("bne_branch", 32'(branch), 1);

    run(rtype(5'd0, 5'd2, 5'd3, 5'd4, 6'h03), 0, 0, 32'h80000000);
    check("sra_result", alu_result, 32'hF8000000);
    run(rtype(5'd0, 5'd2, 5'd3, 5'd4, 6'h02), 0, 0, 32'h80000000);
    check("srl_result", alu_result, 32'h08000000);
    run(rtype(5'd0, 5'd2, 5'd3, 5'd8, 6'h00), 0, 0, 32'h00FF00FF);
    check("sll_result", alu_result, 32'hFF00FF00);
    run(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h27), 0, 32'hF0F00000, 32'h0000000F);
    check("nor_result", alu_result, 32'h0F0FFFF0);
    run(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h2A), 0, 32'hFFFFFFFF, 1);
    check("slt_result", alu_result, 1);
    run(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h2B), 0, 32'hFFFFFFFF, 1);
    check("sltu_result", alu_result, 0);
    run(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h22), 0, 3, 10);
    check("sub_result", alu_result, 32'hFFFFFFF9);

    run(itype(6'h0F, 5'd0, 5'd4, 16'hABCD), 0, 32'h5555, 0);
    check("lui_result", alu_result, 32'hABCD0000);
    check("lui_reg_dst", 32'(reg_dst), 0);
    check("lui_dest", 32'(dest_reg), 4);
    check("lui_write_reg", 32'(write_reg), 1);
    run(itype(6'h0D, 5'd0, 5'd5, 16'h8001), 0, 0, 0);
    check("ori_result", alu_result, 32'h00008001);
    run(itype(6'h0E, 5'd1, 5'd5, 16'h8000), 0, 32'hFFFF0000, 0);
    check("xori_result", alu_result, 32'hFFFF8000);
    run(itype(6'h08, 5'd1, 5'd5, 16'hFFFE), 0, 5, 0);
    check("addi_neg_result", alu_result, 3);
    run(itype(6'h0A, 5'd1, 5'd5, 16'hFFFF), 0, 32'hFFFFFFF0, 0);
    check("slti_result", alu_result, 1);
    run(itype(6'h0B, 5'd1, 5'd5, 16'hFFFF), 0, 5, 0);
    check("sltiu_result", alu_result, 1);

    run(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h20), 0, 32'h7FFFFFFF, 1);
    check("addovf_result", alu_result, 32'h80000000);
`ifdef ALU32_OVERFLOW_TRAP_EN
    check("addovf_flag", 32'(overflow), 1);
    check("addovf_write_reg", 32'(write_reg), 0);
`else
    check("addovf_flag", 32'(overflow), 0);
    check("addovf_write_reg", 32'(write_reg), 1);
`endif
    run(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h21), 0, 32'h7FFFFFFF, 1);
    check("addu_flag", 32'(overflow), 0);
    check("addu_write_reg", 32'(write_reg), 1);

    run(itype(6'h23, 5'd1, 5'd6, 16'hFFFC), 0, 32'h100, 0);
    check("lw_result", alu_result, 32'hFC);
    check("lw_read_mem", 32'(read_mem), 1);
    check("lw_dest", 32'(dest_reg), 6);
    check("lw_write_reg", 32'(write_reg), 1);
    run(itype(6'h2B, 5'd1, 5'd6, 16'h0008), 0, 32'h100, 0);
    check("sw_result", alu_result, 32'h108);
    check("sw_write_mem", 32'(write_mem), 1);
    check("sw_write_reg", 32'(write_reg), 0);

    run({6'h03, 26'h0000123}, 32'h40, 0, 0);
    check("jal_result", alu_result, 32'h41);
    check("jal_dest", 32'(dest_reg), 31);
    check("jal_write_reg", 32'(write_reg), 1);
    check("jal_address", 32'(address), 32'h123);
    run({6'h02, 26'h0000456}, 32'h40, 7, 7);
    check("j_result", alu_result, 0);
    check("j_read_reg", 32'(read_reg), 0);
    run(rtype(5'd1, 5'd0, 5'd0, 5'd0, 6'h08), 0, 32'h1000, 0);
    check("jr_result", alu_result, 32'h1000);
    check("jr_write_reg", 32'(write_reg), 0);

    run(32'hFC221234, 0, 32'h11, 32'h22);
    check("ill_flag", 32'(illegal), 1);
    check("ill_result", alu_result, 0);
    check("ill_read_reg", 32'(read_reg), 0);
    check("ill_write_reg", 32'(write_reg), 0);
    check("ill_opcode", 32'(opcode), 32'h3F);
    check("ill_rs_field", 32'(rs), 1);
    run(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h3F), 0, 1, 2);
    check("ill_funct_flag", 32'(illegal), 1);
    check("ill_funct_reg_dst", 32'(reg_dst), 0);

    // Idle cycle: out_valid drops, the illegal decode stays visible.
    @(negedge clock);
    in_valid = 1'b0;
    instruction = 32'h00A53820;
    @(posedge clock);
    #1;
    check("idle_out_valid", 32'(out_valid), 0);
    check("idle_illegal_hold", 32'(illegal), 1);
    check("idle_funct_hold", 32'(funct), 32'h3F);

    run(32'h00A53820, 0, 5, 7);
    check("pre_rst_result", alu_result, 12);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 0);
    check("mid_rst_result", alu_result, 0);
    check("mid_rst_zero", 32'(zero), 1);
    check("mid_rst_dest", 32'(dest_reg), 0);
    @(negedge clock);
    in_valid = 1'b0;
    reset_n  = 1'b1;
    @(posedge clock);
    #1;
    check("post_rst_out_valid", 32'(out_valid), 0);
    check("post_rst_result", alu_result, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
